ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: ports clk and rst_n.
REQ-002 The block SHALL expose parameter OVF_CODE, default 5'd12, the exception code reported for arithmetic overflow.
REQ-003 The block SHALL expose parameter DEPTH, default 2, fixed buffer entries (main + skid); other values unsupported.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  upstream (execute) result valid.
REQ-007 in_ready  out  1  stage can accept; registered, not combinationally dependent on out_ready.
REQ-008 alu_rd  in  32  execute-stage result.
REQ-009 alu_overflow  in  1  execute-stage signed overflow flag.
REQ-010 ovf_en  in  1  instruction traps on overflow (signed add/sub).
REQ-011 pc, store_data  in  32 each  instruction PC; rt value for stores.
REQ-012 dest_reg  in  5; reg_write, mem_read, mem_write  in  1 each  control bits.
REQ-013 flush  in  1  kill all held and incoming entries.
REQ-014 out_valid  out  1; out_ready  in  1  downstream (memory stage) handshake.
REQ-015 out_alu_result, out_store_data, out_pc  out  32 each; out_dest_reg  out  5; out_reg_write, out_mem_read, out_mem_write  out  1 each.
REQ-016 exc_valid  out  1  one-cycle exception pulse; exc_epc  out  32; exc_code  out  5.

Function
REQ-017 Transfer in SHALL occur on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-018 Accepted entry SHALL appear on outputs the next cycle when buffer empty (latency 1).
REQ-019 Buffer SHALL hold 2 entries; in_ready SHALL be 1 iff fewer than 2 entries held at cycle start (or state TRAP).
REQ-020 Entries SHALL leave in acceptance order; simultaneous accept and release with 1 held keeps count 1, no bubble.
REQ-021 out_* SHALL be stable while out_valid && !out_ready.
REQ-022 Accepted entry with ovf_en && alu_overflow SHALL be stored with reg_write, mem_read, mem_write forced 0, still passed downstream.
REQ-023 On that acceptance, next cycle exc_valid=1 for exactly one cycle, exc_epc=pc, exc_code=OVF_CODE.
REQ-024 alu_overflow with ovf_en=0 SHALL be ignored.
REQ-025 FSM states RUN, TRAP; reset -> RUN.
REQ-026 RUN -> TRAP on acceptance of an overflowing entry; TRAP -> RUN on flush.
REQ-027 In TRAP, in_ready=1 and all accepted inputs SHALL be discarded (no storage, no exception).
REQ-028 flush SHALL empty the buffer next cycle, drop any same-cycle input, suppress a same-cycle exc_valid set, and take priority over all other events.
REQ-029 Two overflowing entries SHALL never both raise exc_valid (second is discarded in TRAP).
REQ-030 Widths SHALL pass through unchanged; no arithmetic performed on data.

Reset
REQ-031 With rst_n=0 at a clock edge: buffer empty, state RUN, out_valid=0, exc_valid=0, in_ready=1, all data outputs 32'd0/5'd0/1'b0.
REQ-032 Reset mid-transfer SHALL discard held entries without an exception pulse.

Structure
REQ-033 Shared package SHALL hold the RUN/TRAP state encoding, EXC_OV=5'd12, and the entry bundle typedef (result, store_data, pc, dest_reg, three control bits).
REQ-034 One sub-module SHALL be natural: skid_buf (2-entry valid/ready buffer, generic over bundle width); FSM and exception logic in ex_mem_stage.

Verification
REQ-035 Reset then in_valid=1, alu_rd=32'h1234, dest_reg=5'd8, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_alu_result=32'h1234, out_reg_write=1.
REQ-036 out_ready=0, push 3 entries back-to-back -> in_ready falls after 2nd accept; release order A,B; third accepted only after a pop.
REQ-037 ovf_en=1, alu_overflow=1, pc=32'h0040_0010, reg_write=1 -> exc_valid one cycle, exc_epc=32'h0040_0010, exc_code=5'd12, out_reg_write=0.
REQ-038 After REQ-037, inputs for 3 cycles then flush -> none appear, no exc_valid; post-flush entry flows normally.
REQ-039 flush in same cycle as an overflowing accept -> no exc_valid, buffer empty, state RUN.
REQ-040 rst_n=0 with 2 entries held -> next cycle out_valid=0, in_ready=1, exc_valid=0.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared definitions for the EX/MEM pipeline stage.
//   state_t  : trap FSM encoding (RUN, TRAP)
//   EXC_OV   : exception code reported for signed arithmetic overflow
//   entry_t  : one buffered instruction (result, store data, pc, dest, controls)
//   ENTRY_W  : packed width of entry_t, used to size the generic buffer
package ex_mem_stage_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

   localparam logic [4:0] EXC_OV = 5'd12;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store_data;
      logic [31:0] pc;
      logic [4:0]  dest_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ex_mem_stage_skid_buf.sv
// ex_mem_stage_skid_buf
// Two-entry valid/ready buffer (main + skid), generic over payload width W.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               drop every held entry next cycle
//   in_valid/in_ready   upstream handshake; in_ready depends only on held count
//   in_data [W]         payload written on an accepted transfer
//   out_valid/out_ready downstream handshake
//   out_data [W]        oldest held entry (stable until popped)
module ex_mem_stage_skid_buf
   import ex_mem_stage_pkg::*;
#(
   parameter int W     = ENTRY_W,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0] count;
   logic [W-1:0]  head;
   logic [W-1:0]  tail;
   logic          push;
   logic          pop;

   // Ready is a decode of the registered count only, so there is no
   // combinational path from out_ready back to in_ready.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign out_data  = head;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head always holds the oldest entry; tail is the skid slot that only
   // fills when a push arrives while head is still waiting. A simultaneous
   // push and pop with one entry held refills head directly (no bubble).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else if (clear) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == '0) head <= in_data;
               else             tail <= in_data;
               count <= count + CW'(1);
            end
            2'b01: begin
               head  <= tail;
               count <= count - CW'(1);
            end
            2'b11: begin
               if (count == CW'(1)) begin
                  head <= in_data;
               end else begin
                  head <= tail;
                  tail <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register with a two-entry skid buffer and overflow trap.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid / in_ready             execute-side handshake
//   alu_rd, alu_overflow, ovf_en    result and overflow qualification
//   pc, store_data, dest_reg        instruction data
//   reg_write, mem_read, mem_write  control bits
//   flush                           kill held and incoming entries
//   out_valid / out_ready           memory-side handshake
//   out_*                           buffered entry presented downstream
//   exc_valid, exc_epc, exc_code    one-cycle overflow exception report
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter logic [4:0] OVF_CODE = EXC_OV,
   parameter int         DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] alu_rd,
   input  logic        alu_overflow,
   input  logic        ovf_en,
   input  logic [31:0] pc,
   input  logic [31:0] store_data,
   input  logic [4:0]  dest_reg,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_alu_result,
   output logic [31:0] out_store_data,
   output logic [31:0] out_pc,
   output logic [4:0]  out_dest_reg,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        exc_valid,
   output logic [31:0] exc_epc,
   output logic [4:0]  exc_code
);

   state_t state;
   state_t state_next;
   logic   buf_ready;
   logic   buf_push;
   logic   ovf_hit;
   logic   traps;
   entry_t in_entry;
   entry_t out_entry;

   // A trapping instruction still travels downstream so the memory stage
   // sees it, but it must not write anything architecturally.
   assign traps = ovf_en && alu_overflow;

   always_comb begin
      in_entry            = '0;
      in_entry.result     = alu_rd;
      in_entry.store_data = store_data;
      in_entry.pc         = pc;
      in_entry.dest_reg   = dest_reg;
      in_entry.reg_write  = reg_write && !traps;
      in_entry.mem_read   = mem_read  && !traps;
      in_entry.mem_write  = mem_write && !traps;
   end

   // Trap state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end

   // In TRAP everything offered is swallowed (ready held high, nothing
   // stored) until a flush redirects the pipeline. Flush overrides every
   // other event, including a same-cycle overflowing accept.
   always_comb begin
      state_next = state;
      in_ready   = buf_ready;
      buf_push   = 1'b0;
      ovf_hit    = 1'b0;
      case (state)
         RUN: begin
            buf_push = in_valid && buf_ready && !flush;
            ovf_hit  = buf_push && traps;
            if (ovf_hit) state_next = TRAP;
         end
         TRAP: begin
            in_ready = 1'b1;
         end
         default: ;
      endcase
      if (flush) state_next = RUN;
   end

   // Exception report: a single-cycle pulse following the overflowing
   // accept. A second pulse cannot follow because TRAP discards input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exc_valid <= 1'b0;
         exc_epc   <= 32'd0;
         exc_code  <= 5'd0;
      end else begin
         exc_valid <= ovf_hit;
         if (ovf_hit) begin
            exc_epc  <= pc;
            exc_code <= OVF_CODE;
         end
      end
   end

   ex_mem_stage_skid_buf #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .in_valid  (buf_push),
      .in_ready  (buf_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_entry)
   );

   assign out_alu_result = out_entry.result;
   assign out_store_data = out_entry.store_data;
   assign out_pc         = out_entry.pc;
   assign out_dest_reg   = out_entry.dest_reg;
   assign out_reg_write  = out_entry.reg_write;
   assign out_mem_read   = out_entry.mem_read;
   assign out_mem_write  = out_entry.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Scoreboard bench for ex_mem_stage: stimulus pushes expected entries and
// exception reports into queues, a monitor pops and compares them whenever
// the DUT presents output.
module tb_ex_mem_stage;

   typedef struct {
      logic [31:0] res;
      logic [31:0] sd;
      logic [31:0] pc;
      logic [4:0]  dest;
      logic        rw;
      logic        mr;
      logic        mw;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] alu_rd = '0;
   logic        alu_overflow = 1'b0;
   logic        ovf_en = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  dest_reg = '0;
   logic        reg_write = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_alu_result;
   logic [31:0] out_store_data;
   logic [31:0] out_pc;
   logic [4:0]  out_dest_reg;
   logic        out_reg_write;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        exc_valid;
   logic [31:0] exc_epc;
   logic [4:0]  exc_code;

   exp_t        exp_q[$];
   logic [31:0] exc_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          pend = 1'b0;
   bit          started = 1'b0;
   bit          kill_prev = 1'b1;
   bit          trap_m = 1'b0;
   bit          last_acc = 1'b0;

   ex_mem_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_rd         (alu_rd),
      .alu_overflow   (alu_overflow),
      .ovf_en         (ovf_en),
      .pc             (pc),
      .store_data     (store_data),
      .dest_reg       (dest_reg),
      .reg_write      (reg_write),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_alu_result (out_alu_result),
      .out_store_data (out_store_data),
      .out_pc         (out_pc),
      .out_dest_reg   (out_dest_reg),
      .out_reg_write  (out_reg_write),
      .out_mem_read   (out_mem_read),
      .out_mem_write  (out_mem_write),
      .exc_valid      (exc_valid),
      .exc_epc        (exc_epc),
      .exc_code       (exc_code)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] res, input logic [31:0] pcv, input logic [4:0] dest,
                               input logic rw, input logic mr, input logic mw);
      exp_t d;
      d.res = res; d.sd = $urandom; d.pc = pcv; d.dest = dest;
      d.rw = rw; d.mr = mr; d.mw = mw;
      return d;
   endfunction

   // One cycle of stimulus, driven 1 time unit after the rising edge. The
   // model decides acceptance from its own occupancy and trap flag, checks
   // in_ready against it, and queues what should come out.
   task automatic applyStimulus(input bit iv, input exp_t d, input bit ovfe, input bit ovf,
                                input bit ordy, input bit fl, input bit rstn);
      bit   model_ready;
      exp_t e;
      @(posedge clk);
      #1;
      if (kill_prev) begin
         exp_q.delete();
         trap_m = 1'b0;
      end
      model_ready = trap_m || (exp_q.size() < 2);
      checkOutput("in_ready", in_ready, model_ready);
      in_valid = iv; alu_rd = d.res; store_data = d.sd; pc = d.pc; dest_reg = d.dest;
      reg_write = d.rw; mem_read = d.mr; mem_write = d.mw;
      ovf_en = ovfe; alu_overflow = ovf; out_ready = ordy; flush = fl; rst_n = rstn;
      last_acc = iv && model_ready;
      pend = 1'b0;
      if (iv && model_ready && !fl && rstn && !trap_m) begin
         e = d;
         if (ovfe && ovf) begin
            e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
            exc_q.push_back(d.pc);
            trap_m = 1'b1;
         end
         exp_q.push_back(e);
         pend = 1'b1;
      end
      kill_prev = fl || !rstn;
   endtask

   task automatic idleStep(input bit ordy);
      applyStimulus(1'b0, mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, ordy, 1'b0, 1'b1);
   endtask

   // Monitor: on the falling edge compare whatever the DUT presents with the
   // front of the scoreboard; pop when the downstream transfer will happen.
   initial begin
      int   held;
      exp_t e;
      logic [31:0] epc;
      forever begin
         @(negedge clk);
         if (started) begin
            held = exp_q.size() - (pend ? 1 : 0);
            checkOutput("out_valid", out_valid, held > 0);
            if (out_valid === 1'b1 && held > 0) begin
               e = exp_q[0];
               checkOutput("out_entry",
                  {out_alu_result, out_store_data, out_pc, out_dest_reg, out_reg_write, out_mem_read, out_mem_write},
                  {e.res, e.sd, e.pc, e.dest, e.rw, e.mr, e.mw});
               if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
            if (exc_valid === 1'b1) begin
               if (exc_q.size() == 0) begin
                  checkOutput("exc_unexpected", exc_valid, 1'b0);
               end else begin
                  epc = exc_q.pop_front();
                  checkOutput("exc_epc", exc_epc, epc);
                  checkOutput("exc_code", exc_code, 5'd12);
               end
            end
         end
      end
   end

   initial begin
      bit fl;
      bit rn;
      $display("[TB] start");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_exc_valid", exc_valid, 1'b0);
      checkOutput("rst_out_data", {out_alu_result, out_store_data, out_pc, out_dest_reg,
                                   out_reg_write, out_mem_read, out_mem_write}, 128'd0);
      checkOutput("rst_exc_data", {exc_epc, exc_code}, 37'd0);
      started = 1'b1;

      // Basic latency-1 pass-through.
      applyStimulus(1'b1, mk(32'h1234, 32'h100, 5'd8, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idleStep(1'b1);
      checkOutput("lat1_valid", out_valid, 1'b1);
      checkOutput("lat1_result", out_alu_result, 32'h1234);
      checkOutput("lat1_rw", out_reg_write, 1'b1);
      idleStep(1'b1);

      // Backpressure: A, B fill the buffer, C must wait for a pop.
      applyStimulus(1'b1, mk(32'hA, 32'h200, 5'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, mk(32'hB, 32'h204, 5'd2, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, mk(32'hC, 32'h208, 5'd3, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("full_no_accept", last_acc, 1'b0);
      for (int i = 0; i < 10 && !last_acc; i++)
         applyStimulus(1'b1, mk(32'hC, 32'h208, 5'd3, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("c_accepted", last_acc, 1'b1);
      repeat (3) idleStep(1'b1);

      // Overflow trap, discarded inputs in TRAP, flush, then normal flow.
      applyStimulus(1'b1, mk(32'h7FFF_FFFF, 32'h0040_0010, 5'd9, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      idleStep(1'b1);
      checkOutput("trap_exc_valid", exc_valid, 1'b1);
      checkOutput("trap_exc_epc", exc_epc, 32'h0040_0010);
      checkOutput("trap_exc_code", exc_code, 5'd12);
      checkOutput("trap_out_rw", out_reg_write, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, mk($urandom, 32'h500 + 32'(i), 5'd4, 1'b1, 1'b0, 1'b0), 1'b1, 1'(i == 1), 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, mk(32'h55, 32'h600, 5'd5, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (2) idleStep(1'b1);

      // Flush in the same cycle as an overflowing accept: nothing happens,
      // and a later overflow still traps normally.
      applyStimulus(1'b1, mk(32'h1, 32'h700, 5'd6, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      idleStep(1'b1);
      checkOutput("flushovf_exc", exc_valid, 1'b0);
      checkOutput("flushovf_valid", out_valid, 1'b0);
      applyStimulus(1'b1, mk(32'h2, 32'h704, 5'd7, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (2) idleStep(1'b1);
      applyStimulus(1'b0, mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Reset with two entries held.
      applyStimulus(1'b1, mk(32'hD1, 32'h800, 5'd10, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, mk(32'hD2, 32'h804, 5'd11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idleStep(1'b1);
      checkOutput("midrst_valid", out_valid, 1'b0);
      checkOutput("midrst_ready", in_ready, 1'b1);
      checkOutput("midrst_exc", exc_valid, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         fl = ($urandom_range(0, 99) < (trap_m ? 20 : 3));
         rn = !($urandom_range(0, 199) == 0);
         applyStimulus($urandom_range(0, 99) < 70,
                       mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)),
                       1'($urandom), $urandom_range(0, 99) < 20,
                       (fl || !rn) ? 1'b0 : ($urandom_range(0, 99) < 60), fl, rn);
      end

      // Drain and clear any trap, then everything queued must have appeared.
      applyStimulus(1'b0, mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (6) idleStep(1'b1);
      checkOutput("drain_exp_q", exp_q.size(), 0);
      checkOutput("drain_exc_q", exc_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
